bus_select_arbiter: RTL and testbench

//   Round-robin arbiter for four requesters sharing one tri-state bus.

---
 rtl/bus_select_arbiter.sv | 114 +++++++++++
 tb/tb_bus_select_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bus_select_arbiter.sv
// Round-robin arbiter for four requesters sharing one tri-state bus.
// Bursts are bounded, and a one-cycle turnaround separates successive owners.
module bus_select_arbiter #(
   parameter int MAX_BURST = 8,
   parameter int CNT_W     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [1:2] s,
   output logic       enable,
   output logic [3:0] gnt,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BURST);

   state_e           state_q, state_d;
   logic [1:0]       s_q, s_d;
   logic [1:0]       last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             enable_q, enable_d;
   logic [3:0]       gnt_q, gnt_d;
   logic             busy_q, busy_d;

   logic [1:0]       arbIdx;
   logic             arbAny;
   logic [1:0]       cand;

   // Scan starts just after the last owner, so the previous owner is checked last.
   always_comb begin
      arbIdx = last_q;
      arbAny = 1'b0;
      cand   = last_q;
      for (int k = 1; k <= 4; k++) begin
         cand = last_q + 2'(k);
         if (!arbAny && req[cand]) begin
            arbIdx = cand;
            arbAny = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      enable_d = 1'b0;
      gnt_d    = 4'b0000;
      busy_d   = 1'b0;
      case (state_q)
         IDLE, TURN: begin
            if (arbAny) begin
               state_d  = GRANT;
               s_d      = arbIdx;
               cnt_d    = CNT_W'(1);
               enable_d = 1'b1;
               gnt_d    = 4'b0001 << arbIdx;
               busy_d   = 1'b1;
            end else begin
               state_d  = IDLE;
            end
         end
         GRANT: begin
            busy_d = 1'b1;
            // A dropped request takes precedence over any new request this edge.
            if (!req[s_q] || (cnt_q == MaxCnt)) begin
               state_d = TURN;
               last_d  = s_q;
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
               enable_d = 1'b1;
               gnt_d    = 4'b0001 << s_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         s_q      <= 2'd0;
         last_q   <= 2'd3;
         cnt_q    <= '0;
         enable_q <= 1'b0;
         gnt_q    <= 4'b0000;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         enable_q <= enable_d;
         gnt_q    <= gnt_d;
         busy_q   <= busy_d;
      end
   end

   assign s      = s_q;
   assign enable = enable_q;
   assign gnt    = gnt_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Directed bench for bus_select_arbiter: one instance with the default burst
// length and a second instance with single-cycle bursts.
module tb_bus_select_arbiter;

   logic       clk;
   logic       rstA, rstB;
   logic [3:0] reqA, reqB;
   logic [1:2] sA, sB;
   logic       enableA, enableB;
   logic [3:0] gntA, gntB;
   logic       busyA, busyB;

   int checkCount;
   int failCount;

   bus_select_arbiter #(.MAX_BURST(8), .CNT_W(4)) dutA (
      .clk    (clk),
      .rst    (rstA),
      .req    (reqA),
      .s      (sA),
      .enable (enableA),
      .gnt    (gntA),
      .busy   (busyA)
   );

   bus_select_arbiter #(.MAX_BURST(1), .CNT_W(4)) dutB (
      .clk    (clk),
      .rst    (rstB),
      .req    (reqB),
      .s      (sB),
      .enable (enableB),
      .gnt    (gntB),
      .busy   (busyB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rA, input logic [3:0] qA,
                                input logic rB, input logic [3:0] qB);
      rstA = rA;
      reqA = qA;
      rstB = rB;
      reqB = qB;
   endtask

   // Outputs are packed as {s, enable, gnt, busy} for a single comparison.
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [1:0] expS, input logic expEn,
                              input logic [3:0] expGnt, input logic expBusy);
      logic [7:0] expected;
      expected = {expS, expEn, expGnt, expBusy};
      checkCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed={s=%0d en=%b gnt=%b busy=%b} expected={s=%0d en=%b gnt=%b busy=%b}",
                tag, observed[7:6], observed[5], observed[4:1], observed[0],
                expected[7:6], expected[5], expected[4:1], expected[0]);
      end
   endtask

   function automatic logic [7:0] obsA();
      return {sA, enableA, gntA, busyA};
   endfunction

   function automatic logic [7:0] obsB();
      return {sB, enableB, gntB, busyB};
   endfunction

   function automatic logic [3:0] oneHot(input logic [1:0] idx);
      logic [3:0] one;
      one = 4'b0001;
      return one << idx;
   endfunction

   initial begin
      logic [1:0] order [5];
      checkCount = 0;
      failCount  = 0;
      order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

      // Reset held for two edges while every requester is asking.
      applyStimulus(1'b1, 4'b1111, 1'b1, 4'b0000);
      tick();
      tick();
      checkOutput("reset_state", obsA(), 2'd0, 1'b0, 4'b0000, 1'b0);

      // Release with all requesters active: 0,1,2,3,0, eight cycles each.
      applyStimulus(1'b0, 4'b1111, 1'b1, 4'b0000);
      for (int o = 0; o < 5; o++) begin
         for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput($sformatf("burst8_owner%0d_cyc%0d", order[o], k + 1), obsA(),
                        order[o], 1'b1, oneHot(order[o]), 1'b1);
         end
         tick();
         checkOutput($sformatf("burst8_turn_after%0d", order[o]), obsA(),
                     order[o], 1'b0, 4'b0000, 1'b1);
      end

      // Single requester 2 for three edges, then idle.
      applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0000);
      tick();
      applyStimulus(1'b0, 4'b0100, 1'b1, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput($sformatf("single2_grant%0d", k + 1), obsA(), 2'd2, 1'b1, 4'b0100, 1'b1);
      end
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000);
      tick();
      checkOutput("single2_turn", obsA(), 2'd2, 1'b0, 4'b0000, 1'b1);
      tick();
      checkOutput("single2_idle", obsA(), 2'd2, 1'b0, 4'b0000, 1'b0);

      // Requesters 0 and 3 together; owner 0 drops, then 3 gets the bus.
      applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0000);
      tick();
      applyStimulus(1'b0, 4'b1001, 1'b1, 4'b0000);
      tick();
      checkOutput("pair_owner0_a", obsA(), 2'd0, 1'b1, 4'b0001, 1'b1);
      tick();
      checkOutput("pair_owner0_b", obsA(), 2'd0, 1'b1, 4'b0001, 1'b1);
      applyStimulus(1'b0, 4'b1000, 1'b1, 4'b0000);
      tick();
      checkOutput("pair_turn0", obsA(), 2'd0, 1'b0, 4'b0000, 1'b1);
      tick();
      checkOutput("pair_owner3", obsA(), 2'd3, 1'b1, 4'b1000, 1'b1);

      // Owner drops and another raises on the same edge: the drop wins.
      applyStimulus(1'b0, 4'b0010, 1'b1, 4'b0000);
      tick();
      checkOutput("drop_wins_turn", obsA(), 2'd3, 1'b0, 4'b0000, 1'b1);
      tick();
      checkOutput("drop_wins_owner1", obsA(), 2'd1, 1'b1, 4'b0010, 1'b1);
      applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000);
      tick();
      checkOutput("drop_wins_turn1", obsA(), 2'd1, 1'b0, 4'b0000, 1'b1);
      tick();
      checkOutput("drop_wins_idle", obsA(), 2'd1, 1'b0, 4'b0000, 1'b0);

      // Reset mid-burst on the fourth grant cycle of owner 1.
      applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0000);
      tick();
      applyStimulus(1'b0, 4'b0010, 1'b1, 4'b0000);
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput($sformatf("midrst_owner1_cyc%0d", k + 1), obsA(), 2'd1, 1'b1, 4'b0010, 1'b1);
      end
      applyStimulus(1'b1, 4'b0010, 1'b1, 4'b0000);
      tick();
      checkOutput("midrst_cleared", obsA(), 2'd0, 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b0, 4'b0010, 1'b1, 4'b0000);
      tick();
      checkOutput("midrst_regrant1", obsA(), 2'd1, 1'b1, 4'b0010, 1'b1);

      // Single-cycle bursts with requesters 0 and 1 held.
      applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0000);
      tick();
      checkOutput("b1_reset", obsB(), 2'd0, 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0011);
      tick();
      checkOutput("b1_owner0", obsB(), 2'd0, 1'b1, 4'b0001, 1'b1);
      tick();
      checkOutput("b1_turn0", obsB(), 2'd0, 1'b0, 4'b0000, 1'b1);
      tick();
      checkOutput("b1_owner1", obsB(), 2'd1, 1'b1, 4'b0010, 1'b1);
      tick();
      checkOutput("b1_turn1", obsB(), 2'd1, 1'b0, 4'b0000, 1'b1);
      tick();
      checkOutput("b1_owner0_again", obsB(), 2'd0, 1'b1, 4'b0001, 1'b1);
      tick();
      checkOutput("b1_turn0_again", obsB(), 2'd0, 1'b0, 4'b0000, 1'b1);

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule
